// File: rtl/rgb2gray_pkg.sv
// Shared definitions for the RGB-to-gray frame sequencer.
//   state_e     : sequencer FSM state encoding
//   WORD_STRIDE : byte distance between consecutive pixel words
//   TMO_CYC_DEF : default engine-response watchdog length in cycles
package rgb2gray_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_CONV    = 3'd3,
    ST_WR      = 3'd4,
    ST_FIN     = 3'd5
  } state_e;

  localparam int WORD_STRIDE = 4;
  localparam int TMO_CYC_DEF = 15;

endpackage

// File: rtl/rgb2gray_seq_timeout.sv
// Engine watchdog: a down-counter reloaded on each engine start.
//   clk_i, rst_i : clock, async active-low reset
//   load_i       : reload the counter with TMO_CYC
//   en_i         : count down one step per cycle (saturates at 0)
//   expired_o    : counter has reached 0
module rgb2gray_seq_timeout
  import rgb2gray_pkg::*;
#(
  parameter int TMO_CYC = TMO_CYC_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = $clog2(TMO_CYC + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                  cnt_d = CW'(TMO_CYC);
    else if (en_i && cnt_q != '0) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Loaded on the engine-start cycle, so 0 is reached in the TMO_CYC-th
  // waiting cycle after the start pulse.
  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/rgb2gray_frame_seq.sv
// Frame sequencer: for each pixel, read an RGB word over Avalon-MM, hand it
// to an external Rgb2Gray engine, and write the gray result back.
//   clk_i, rst_i          : clock, async active-low reset
//   start_i, src/dst/npix : job launch and parameters
//   busy_o, done_o, err_o : job status (err_o sticky engine timeout)
//   avm_*                 : Avalon-MM master (one outstanding read max)
//   eng_*                 : engine handshake (start pulse / valid strobe)
module rgb2gray_frame_seq
  import rgb2gray_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int CNT_W   = 16,
  parameter int TMO_CYC = TMO_CYC_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] src_addr_i,
  input  logic [ADDR_W-1:0] dst_addr_i,
  input  logic [CNT_W-1:0]  npix_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W-1:0] avm_address_o,
  output logic              avm_read_o,
  output logic              avm_write_o,
  output logic [31:0]       avm_writedata_o,
  input  logic [31:0]       avm_readdata_i,
  input  logic              avm_waitrequest_i,
  input  logic              avm_readdatavalid_i,
  output logic              eng_start_o,
  output logic [23:0]       eng_rgb_o,
  input  logic              eng_valid_i,
  input  logic [7:0]        eng_gray_i
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
  logic [CNT_W-1:0]  npix_q, npix_d, idx_q, idx_d;
  logic [23:0]       pix_q, pix_d;
  logic [7:0]        gray_q, gray_d;
  logic              err_q, err_d;
  logic              eng_start_q, eng_start_d;

  logic              rd_ack, wr_ack, rd_cap, last_pix, tmo_expired;
  logic [ADDR_W-1:0] offset;

  assign rd_ack   = (state_q == ST_RD_REQ) && !avm_waitrequest_i;
  assign wr_ack   = (state_q == ST_WR) && !avm_waitrequest_i;
  // Read data is only meaningful while a read is outstanding.
  assign rd_cap   = (state_q == ST_RD_WAIT) && avm_readdatavalid_i;
  assign last_pix = (idx_q + CNT_W'(1)) == npix_q;
  // Wraps modulo 2^ADDR_W by truncation.
  assign offset   = ADDR_W'(idx_q) * ADDR_W'(WORD_STRIDE);

  rgb2gray_seq_timeout #(.TMO_CYC(TMO_CYC)) u_tmo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (rd_cap),
    .en_i      (state_q == ST_CONV),
    .expired_o (tmo_expired)
  );

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (start_i) state_d = (npix_i != '0) ? ST_RD_REQ : ST_FIN;
      ST_RD_REQ:  if (rd_ack) state_d = ST_RD_WAIT;
      ST_RD_WAIT: if (rd_cap) state_d = ST_CONV;
      ST_CONV:    if (eng_valid_i || tmo_expired) state_d = ST_WR;
      ST_WR:      if (wr_ack) state_d = last_pix ? ST_FIN : ST_RD_REQ;
      ST_FIN:     state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy_o          = (state_q != ST_IDLE);
    done_o          = (state_q == ST_FIN);
    avm_read_o      = (state_q == ST_RD_REQ);
    avm_write_o     = (state_q == ST_WR);
    avm_address_o   = '0;
    avm_writedata_o = '0;
    if (state_q == ST_RD_REQ) avm_address_o = src_q + offset;
    if (state_q == ST_WR) begin
      avm_address_o   = dst_q + offset;
      avm_writedata_o = {24'h0, gray_q};
    end
    eng_start_o = eng_start_q;
    eng_rgb_o   = pix_q;
    err_o       = err_q;
  end

  // Datapath next-state
  always_comb begin
    src_d       = src_q;
    dst_d       = dst_q;
    npix_d      = npix_q;
    idx_d       = idx_q;
    pix_d       = pix_q;
    gray_d      = gray_q;
    err_d       = err_q;
    // Registered so the pulse coincides with pix_q holding the new pixel.
    eng_start_d = rd_cap;
    unique case (state_q)
      ST_IDLE:
        if (start_i && npix_i != '0) begin
          src_d  = src_addr_i;
          dst_d  = dst_addr_i;
          npix_d = npix_i;
          idx_d  = '0;
          err_d  = 1'b0;
        end
      ST_RD_WAIT: if (rd_cap) pix_d = avm_readdata_i[23:0];
      ST_CONV:
        // A result arriving in the expiry cycle still wins.
        if (eng_valid_i) gray_d = eng_gray_i;
        else if (tmo_expired) begin
          gray_d = 8'h00;
          err_d  = 1'b1;
        end
      ST_WR:   if (wr_ack) idx_d = idx_q + CNT_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      src_q       <= '0;
      dst_q       <= '0;
      npix_q      <= '0;
      idx_q       <= '0;
      pix_q       <= '0;
      gray_q      <= '0;
      err_q       <= 1'b0;
      eng_start_q <= 1'b0;
    end else begin
      src_q       <= src_d;
      dst_q       <= dst_d;
      npix_q      <= npix_d;
      idx_q       <= idx_d;
      pix_q       <= pix_d;
      gray_q      <= gray_d;
      err_q       <= err_d;
      eng_start_q <= eng_start_d;
    end
  end

endmodule

// File: tb/tb_rgb2gray_frame_seq.sv
// Directed bench for rgb2gray_frame_seq with an Avalon slave model, an
// engine model (gray = G ^ 0xFF, configurable latency / dropped pixel)
// and a negedge bus monitor.
module tb_rgb2gray_frame_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] src = '0, dst = '0;
  logic [15:0] npix = '0;
  logic        busy, done, err;
  logic [31:0] addr, wdata, rdata;
  logic        rd, wr, waitreq, rdv;
  logic        eng_start, eng_valid = 1'b0;
  logic [23:0] eng_rgb;
  logic [7:0]  eng_gray = '0;

  always #5 clk = ~clk;

  rgb2gray_frame_seq dut (
    .clk_i(clk), .rst_i(rst_n), .start_i(start),
    .src_addr_i(src), .dst_addr_i(dst), .npix_i(npix),
    .busy_o(busy), .done_o(done), .err_o(err),
    .avm_address_o(addr), .avm_read_o(rd), .avm_write_o(wr),
    .avm_writedata_o(wdata), .avm_readdata_i(rdata),
    .avm_waitrequest_i(waitreq), .avm_readdatavalid_i(rdv),
    .eng_start_o(eng_start), .eng_rgb_o(eng_rgb),
    .eng_valid_i(eng_valid), .eng_gray_i(eng_gray)
  );

  int errs = 0, checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Source memory contents (upper byte must be discarded by the DUT).
  function automatic logic [31:0] memfn(input logic [31:0] a);
    case (a)
      32'h0000_0100: memfn = 32'hFF10_2030;
      32'h0000_0104: memfn = 32'hEE40_5060;
      32'h0000_0108: memfn = 32'hDD70_8090;
      32'hFFFF_FFFC: memfn = 32'h000A_0B0C;
      32'h0000_0000: memfn = 32'h00C0_D0E0;
      default:       memfn = 32'hCC12_3456;
    endcase
  endfunction

  // ---------------- Avalon slave model ----------------
  int          wait_cyc = 0;
  int          wcnt = 0;
  logic        rd_pend = 1'b0, inj_rdv = 1'b0;
  logic [31:0] rd_addr_q = '0;

  assign waitreq = (rd | wr) && (wcnt < wait_cyc);
  assign rdv     = rd_pend | inj_rdv;
  assign rdata   = memfn(rd_addr_q);

  always @(posedge clk) begin
    if ((rd | wr) && waitreq) wcnt <= wcnt + 1;
    else                      wcnt <= 0;
    rd_pend <= rd && !waitreq;
    if (rd && !waitreq) rd_addr_q <= addr;
  end

  // ---------------- Engine model ----------------
  int          eng_lat = 2;
  logic        drop_en = 1'b0;
  int          drop_idx = 0;
  logic        e_pend = 1'b0;
  int          e_cnt = 0;
  logic [23:0] e_cap = '0;
  int          rgb_bad = 0;
  int          st_n = 0;

  always @(posedge clk) begin
    eng_valid <= 1'b0;
    if (!rst_n) begin
      e_pend <= 1'b0;
    end else if (eng_start) begin
      e_cap <= eng_rgb;
      if (drop_en && (st_n - 1) == drop_idx) e_pend <= 1'b0;
      else if (eng_lat <= 1) begin
        eng_valid <= 1'b1;
        eng_gray  <= eng_rgb[15:8] ^ 8'hFF;
        e_pend    <= 1'b0;
      end else begin
        e_pend <= 1'b1;
        e_cnt  <= eng_lat - 1;
      end
    end else if (e_pend) begin
      if (e_cnt == 1) begin
        eng_valid <= 1'b1;
        eng_gray  <= e_cap[15:8] ^ 8'hFF;
        e_pend    <= 1'b0;
      end else e_cnt <= e_cnt - 1;
    end
    if (rst_n && (e_pend || eng_valid) && eng_rgb !== e_cap) rgb_bad <= rgb_bad + 1;
  end

  // ---------------- Monitor ----------------
  logic        logclr = 1'b0;
  int          cyc = 0, rd_n = 0, wr_n = 0, done_n = 0, hold_n = 0;
  int          both_n = 0, unstable_n = 0, err_cyc = -1;
  logic [31:0] rd_a [16];
  logic [31:0] wr_a [16];
  logic [31:0] wr_d [16];
  logic [23:0] st_rgb [16];
  int          st_cyc [16];
  logic        p_hold = 1'b0, p_rd = 1'b0, p_wr = 1'b0, err_prev = 1'b0;
  logic [31:0] p_a = '0, p_d = '0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rd && wr) both_n <= both_n + 1;
    if (p_hold && (rd !== p_rd || wr !== p_wr || addr !== p_a || wdata !== p_d))
      unstable_n <= unstable_n + 1;
    p_hold   <= (rd | wr) && waitreq;
    p_rd     <= rd;
    p_wr     <= wr;
    p_a      <= addr;
    p_d      <= wdata;
    err_prev <= err;
    if (logclr) begin
      rd_n <= 0; wr_n <= 0; st_n <= 0; done_n <= 0; hold_n <= 0;
      unstable_n <= 0; err_cyc <= -1;
    end else begin
      if ((rd | wr) && waitreq) hold_n <= hold_n + 1;
      if (rd && !waitreq && rd_n < 16) begin
        rd_a[rd_n] <= addr;
        rd_n       <= rd_n + 1;
      end
      if (wr && !waitreq && wr_n < 16) begin
        wr_a[wr_n] <= addr;
        wr_d[wr_n] <= wdata;
        wr_n       <= wr_n + 1;
      end
      if (eng_start && st_n < 16) begin
        st_rgb[st_n] <= eng_rgb;
        st_cyc[st_n] <= cyc;
        st_n         <= st_n + 1;
      end
      if (done) done_n <= done_n + 1;
      if (err && !err_prev) err_cyc <= cyc;
    end
  end

  // ---------------- Stimulus helpers ----------------
  task automatic clear_logs();
    @(posedge clk); #1 logclr = 1'b1;
    @(negedge clk); #1 logclr = 1'b0;
  endtask

  task automatic pulse_start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
    @(negedge clk);
    src = s; dst = d; npix = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < limit && !seen; k++) begin
      @(negedge clk); #1;
      if (done_n != 0) seen = 1'b1;
    end
    chk(tag, seen, 1'b1);
    repeat (3) @(negedge clk);
    #1;
  endtask

  // ---------------- Test sequence ----------------
  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_rd", rd, 0);
    chk("rst_wr", wr, 0);
    chk("rst_eng_start", eng_start, 0);
    chk("rst_addr", addr, 0);
    chk("rst_rgb", eng_rgb, 0);
    @(negedge clk); rst_n = 1'b1;

    // Unsolicited readdatavalid while idle
    @(negedge clk); inj_rdv = 1'b1;
    @(negedge clk); inj_rdv = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("unsol_busy", busy, 0);
    chk("unsol_eng_start", st_n, 0);

    // Basic 3-pixel job, no waitrequest, engine latency 2
    clear_logs();
    pulse_start(32'h100, 32'h200, 16'd3);
    wait_done("t1_done", 200);
    chk("t1_rd_n", rd_n, 3);
    chk("t1_rd0", rd_a[0], 32'h100);
    chk("t1_rd1", rd_a[1], 32'h104);
    chk("t1_rd2", rd_a[2], 32'h108);
    chk("t1_wr_n", wr_n, 3);
    chk("t1_wa0", wr_a[0], 32'h200);
    chk("t1_wa1", wr_a[1], 32'h204);
    chk("t1_wa2", wr_a[2], 32'h208);
    chk("t1_wd0", wr_d[0], 32'h0000_00DF);
    chk("t1_wd1", wr_d[1], 32'h0000_00AF);
    chk("t1_wd2", wr_d[2], 32'h0000_007F);
    chk("t1_rgb0", st_rgb[0], 24'h102030);
    chk("t1_rgb1", st_rgb[1], 24'h405060);
    chk("t1_rgb2", st_rgb[2], 24'h708090);
    chk("t1_done_n", done_n, 1);
    chk("t1_err", err, 0);
    chk("t1_busy", busy, 0);

    // npix = 0: immediate completion, no bus traffic
    clear_logs();
    pulse_start(32'h100, 32'h200, 16'd0);
    #1;
    chk("t2_done_now", done, 1);
    repeat (3) @(negedge clk);
    #1;
    chk("t2_done_n", done_n, 1);
    chk("t2_traffic", rd_n + wr_n, 0);
    chk("t2_busy", busy, 0);

    // waitrequest held 5 cycles on every command
    clear_logs();
    wait_cyc = 5;
    pulse_start(32'h100, 32'h300, 16'd2);
    wait_done("t3_done", 300);
    chk("t3_hold_n", hold_n, 20);
    chk("t3_unstable", unstable_n, 0);
    chk("t3_rd0", rd_a[0], 32'h100);
    chk("t3_rd1", rd_a[1], 32'h104);
    chk("t3_wa0", wr_a[0], 32'h300);
    chk("t3_wa1", wr_a[1], 32'h304);
    chk("t3_wd0", wr_d[0], 32'h0000_00DF);
    chk("t3_wd1", wr_d[1], 32'h0000_00AF);
    chk("t3_done_n", done_n, 1);
    wait_cyc = 0;

    // Engine never answers pixel 1 of 2: timeout path
    clear_logs();
    drop_en = 1'b1; drop_idx = 1;
    pulse_start(32'h100, 32'h400, 16'd2);
    wait_done("t4_done", 300);
    chk("t4_err", err, 1);
    // Expiry in the 15th cycle after the start pulse, flag seen the next.
    chk("t4_err_lat", err_cyc - st_cyc[1], 16);
    chk("t4_wr_n", wr_n, 2);
    chk("t4_wd0", wr_d[0], 32'h0000_00DF);
    chk("t4_wa1", wr_a[1], 32'h404);
    chk("t4_wd1", wr_d[1], 32'h0000_0000);
    chk("t4_done_n", done_n, 1);
    drop_en = 1'b0;

    // Reset asserted during the write of pixel 1
    clear_logs();
    wait_cyc = 3;
    pulse_start(32'h100, 32'h200, 16'd3);
    begin
      logic found;
      found = 1'b0;
      for (int k = 0; k < 300 && !found; k++) begin
        @(negedge clk);
        if (wr && addr == 32'h204) found = 1'b1;
      end
      chk("t5_reached_wr1", found, 1'b1);
    end
    rst_n = 1'b0;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_err", err, 0);
    chk("t5_rd", rd, 0);
    chk("t5_wr", wr, 0);
    chk("t5_eng_start", eng_start, 0);
    chk("t5_rgb", eng_rgb, 0);
    repeat (3) @(negedge clk);
    #1;
    chk("t5_no_done", done_n, 0);
    @(negedge clk); rst_n = 1'b1;
    wait_cyc = 0;
    clear_logs();
    pulse_start(32'h100, 32'h200, 16'd3);
    wait_done("t5b_done", 200);
    chk("t5b_wr_n", wr_n, 3);
    chk("t5b_wa0", wr_a[0], 32'h200);
    chk("t5b_wd1", wr_d[1], 32'h0000_00AF);
    chk("t5b_wd2", wr_d[2], 32'h0000_007F);
    chk("t5b_done_n", done_n, 1);

    // Mid-job re-pulse ignored; source address wraps
    clear_logs();
    pulse_start(32'hFFFF_FFFC, 32'h500, 16'd2);
    repeat (3) @(negedge clk);
    #1;
    chk("t6_busy_at_repulse", busy, 1);
    pulse_start(32'h100, 32'h600, 16'd5);
    wait_done("t6_done", 300);
    repeat (4) @(negedge clk);
    #1;
    chk("t6_rd_n", rd_n, 2);
    chk("t6_rd0", rd_a[0], 32'hFFFF_FFFC);
    chk("t6_rd1", rd_a[1], 32'h0000_0000);
    chk("t6_wa0", wr_a[0], 32'h500);
    chk("t6_wa1", wr_a[1], 32'h504);
    chk("t6_wd0", wr_d[0], 32'h0000_00F4);
    chk("t6_wd1", wr_d[1], 32'h0000_002F);
    chk("t6_done_n", done_n, 1);
    chk("t6_busy", busy, 0);

    // Whole-run invariants
    chk("rd_wr_overlap", both_n, 0);
    chk("rgb_stable", rgb_bad, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
